input_circuit: RTL

- Serial-to-parallel front end of the 64-point FFT processor; mirror of the output serializer.
- Accepts one 32-bit complex sample per cycle (real [31:16], imaginary [15:0], both signed 16-bit).
- Applies the real/imaginary interchange for IFFT mode, then packs 8 consecutive samples into one 8-lane word for the butterfly core.
- Each 64-sample frame is 8 groups of 8 lanes; a double buffer (collect register plus holding register) absorbs core back-pressure.

---
 rtl/input_circuit_if.sv | 32 +++
 rtl/input_circuit.sv | 85 ++++++++
 2 files changed

// File: rtl/input_circuit_if.sv
// rtl/input_circuit_if.sv - serial sample in / 8-lane word out handshake bundle
// INPUT_FRAME_SYNC_EN adds din_sof.
interface input_circuit_if #(parameter int DATA_W = 32);
  logic              mode;
  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic              din_ready;
`ifdef INPUT_FRAME_SYNC_EN
  logic              din_sof;
`endif
  logic [DATA_W-1:0] Q1, Q2, Q3, Q4, Q5, Q6, Q7, Q8;
  logic              q_valid;
  logic              q_ready;
  logic [2:0]        group_idx;
  logic              frame_done;

  modport master (
    output mode, din, din_valid, q_ready,
`ifdef INPUT_FRAME_SYNC_EN
    output din_sof,
`endif
    input  din_ready, Q1, Q2, Q3, Q4, Q5, Q6, Q7, Q8, q_valid, group_idx, frame_done
  );

  modport slave (
    input  mode, din, din_valid, q_ready,
`ifdef INPUT_FRAME_SYNC_EN
    input  din_sof,
`endif
    output din_ready, Q1, Q2, Q3, Q4, Q5, Q6, Q7, Q8, q_valid, group_idx, frame_done
  );
endinterface

// File: rtl/input_circuit.sv
// rtl/input_circuit.sv - FFT input serializer: swap for IFFT, pack 8 samples per word
// Optional frame resync on din_sof when INPUT_FRAME_SYNC_EN is defined.
module input_circuit #(
  parameter int DATA_W = 32,
  parameter int LANES  = 8,
  parameter int GROUPS = 8
) (
  input  logic         clk,
  input  logic         rst,
  input_circuit_if.slave io
);
  localparam int LW = $clog2(LANES);
  localparam int GW = $clog2(GROUPS);
  localparam int HW = DATA_W / 2;

  logic [LW-1:0]     lane_cnt;
  logic [GW-1:0]     group_cnt, hold_grp;
  logic [DATA_W-1:0] coll [0:LANES-2];
  logic [DATA_W-1:0] hold [0:LANES-1];
  logic              hold_v, mode_lat, frame_done_r;
  logic              accept, handshake, sof, start, eff_mode, last_lane;
  logic [DATA_W-1:0] sample;

`ifdef INPUT_FRAME_SYNC_EN
  assign sof = io.din_sof;
`else
  assign sof = 1'b0;
`endif

  // Only the completing sample can stall: the first seven lanes always have room.
  assign last_lane    = (lane_cnt == LW'(LANES - 1));
  assign io.din_ready = !(last_lane && hold_v && !io.q_ready);
  assign accept       = io.din_valid && io.din_ready;
  assign handshake    = hold_v && io.q_ready;
  assign start        = sof || (lane_cnt == '0 && group_cnt == '0);
  assign eff_mode     = start ? io.mode : mode_lat;
  assign sample       = eff_mode ? {io.din[HW-1:0], io.din[DATA_W-1:HW]} : io.din;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane_cnt     <= '0;
      group_cnt    <= '0;
      hold_grp     <= '0;
      hold_v       <= 1'b0;
      mode_lat     <= 1'b0;
      frame_done_r <= 1'b0;
      for (int i = 0; i < LANES - 1; i++) coll[i] <= '0;
      for (int i = 0; i < LANES; i++)     hold[i] <= '0;
    end else begin
      frame_done_r <= handshake && (hold_grp == GW'(GROUPS - 1));
      if (handshake) hold_v <= 1'b0;
      if (accept) begin
        if (start) mode_lat <= io.mode;
        if (sof) begin
          coll[0]   <= sample;
          lane_cnt  <= LW'(1);
          group_cnt <= '0;
        end else if (last_lane) begin
          // A new word overrides the clear above, so a concurrent handshake leaves no bubble.
          for (int i = 0; i < LANES - 1; i++) hold[i] <= coll[i];
          hold[LANES-1] <= sample;
          hold_v        <= 1'b1;
          hold_grp      <= group_cnt;
          group_cnt     <= group_cnt + 1'b1;
          lane_cnt      <= '0;
        end else begin
          coll[lane_cnt] <= sample;
          lane_cnt       <= lane_cnt + 1'b1;
        end
      end
    end
  end

  assign io.Q1         = hold[0];
  assign io.Q2         = hold[1];
  assign io.Q3         = hold[2];
  assign io.Q4         = hold[3];
  assign io.Q5         = hold[4];
  assign io.Q6         = hold[5];
  assign io.Q7         = hold[6];
  assign io.Q8         = hold[7];
  assign io.q_valid    = hold_v;
  assign io.group_idx  = hold_grp;
  assign io.frame_done = frame_done_r;
endmodule
